// File: rtl/spio_link_packet_arbiter.sv
// spio_link_packet_arbiter
//   Round-robin arbiter that merges NUM_PORTS SpiNNaker-link packet streams
//   into one packet channel. The output is a single registered stage. Each
//   port can be masked from arbitration, and each port has a forwarded-packet
//   counter for diagnostics.
//   The priority pointer names the most recently granted port. The search
//   starts at the port after it, so a port that keeps requesting waits for at
//   most NUM_PORTS-1 other grants.

`timescale 1ns/1ps

module spio_link_packet_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PKT_BITS  = 72,
  parameter int CNT_BITS  = 32,
  localparam int SEL_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,

  input  logic [NUM_PORTS*PKT_BITS-1:0] IN_DATA_IN,
  input  logic [NUM_PORTS-1:0]          IN_VLD_IN,
  output logic [NUM_PORTS-1:0]          IN_RDY_OUT,

  output logic [PKT_BITS-1:0]           OUT_DATA_OUT,
  output logic                          OUT_VLD_OUT,
  input  logic                          OUT_RDY_IN,

  input  logic [NUM_PORTS-1:0]          ENABLE_IN,
  input  logic [SEL_BITS-1:0]           CNT_SEL_IN,
  input  logic                          CNT_CLR_IN,
  output logic [CNT_BITS-1:0]           CNT_OUT
);

  // Input packets unpacked so that a port can be indexed directly.
  logic [PKT_BITS-1:0]           in_pkt [NUM_PORTS];

  logic [NUM_PORTS-1:0]          req;
  logic                          any_req;
  logic                          accept;
  logic                          in_xfer;
  logic [SEL_BITS-1:0]           sel;
  logic                          sel_found;
  int                            search_idx;
  logic [NUM_PORTS-1:0]          in_rdy;

  logic [SEL_BITS-1:0]           ptr_reg;
  logic                          out_vld_reg;
  logic [PKT_BITS-1:0]           out_data_reg;
  // This flag is low for one cycle after reset, so no port is offered ready
  // in the first cycle after reset is released.
  logic                          ready_en_reg;

  // All counters packed together for the diagnostic read mux.
  logic [NUM_PORTS*CNT_BITS-1:0] cnt_vec;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign in_pkt[gi] = IN_DATA_IN[gi*PKT_BITS +: PKT_BITS];
    end
  endgenerate

  assign req     = IN_VLD_IN & ENABLE_IN;
  assign any_req = |req;
  // The output register can take a new packet when it is empty or is draining
  // in this same cycle. This lets the stage sustain one packet per cycle.
  assign accept  = !out_vld_reg || OUT_RDY_IN;
  // Ready is also gated by the reset input. A producer then never sees a
  // handshake in a cycle whose packet the reset would discard.
  assign in_xfer = accept && any_req && ready_en_reg && !RESET_IN;

  // Round-robin search: find the first requesting port after ptr_reg, wrapping.
  always_comb begin
    sel        = ptr_reg;
    sel_found  = 1'b0;
    search_idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      search_idx = (int'(ptr_reg) + k) % NUM_PORTS;
      if (!sel_found && req[search_idx]) begin
        sel_found = 1'b1;
        sel       = SEL_BITS'(search_idx);
      end
    end
  end

  // One-hot ready toward the selected port. Only a transferring cycle raises it.
  always_comb begin
    in_rdy = '0;
    if (in_xfer) begin
      in_rdy[sel] = 1'b1;
    end
  end

  assign IN_RDY_OUT = in_rdy;

  // Output stage and priority pointer. On a stall or an idle cycle, valid,
  // data and the pointer all keep their values.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
      ptr_reg      <= SEL_BITS'(NUM_PORTS - 1);
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (in_xfer) begin
        out_data_reg <= in_pkt[sel];
        out_vld_reg  <= 1'b1;
        ptr_reg      <= sel;
      end else if (out_vld_reg && OUT_RDY_IN) begin
        out_vld_reg  <= 1'b0;
      end
    end
  end

  assign OUT_DATA_OUT = out_data_reg;
  assign OUT_VLD_OUT  = out_vld_reg;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] cnt_reg;

      // Per-port forwarded-packet counter. It wraps naturally, and a clear in
      // the same cycle as an increment leaves the counter at zero.
      always_ff @(posedge CLK_IN) begin
        if (RESET_IN || CNT_CLR_IN) begin
          cnt_reg <= '0;
        end else if (in_xfer && (sel == SEL_BITS'(gi))) begin
          cnt_reg <= cnt_reg + CNT_BITS'(1);
        end
      end

      assign cnt_vec[gi*CNT_BITS +: CNT_BITS] = cnt_reg;
    end
  endgenerate

  // Diagnostic read mux. A select beyond the last port reads as zero.
  always_comb begin
    CNT_OUT = '0;
    if (int'(CNT_SEL_IN) < NUM_PORTS) begin
      CNT_OUT = cnt_vec[int'(CNT_SEL_IN)*CNT_BITS +: CNT_BITS];
    end
  end

endmodule
